key_click_decoder: RTL and testbench



---
 rtl/key_click_decoder.sv | 117 +++++++++++
 tb/tb_key_click_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// Groups debounced key-press strobes into click events (single, double, ... MAX_CLICKS)
// and presents each finished group through a one-entry valid/ready output register.
module key_click_decoder #(
  parameter int unsigned CLK_FREQ_MHZ    = 5,
  parameter int unsigned CLICK_WINDOW_US = 250000,
  parameter int unsigned MAX_CLICKS      = 3,
  localparam int unsigned W              = CLK_FREQ_MHZ * CLICK_WINDOW_US,
  localparam int unsigned CW             = $clog2(MAX_CLICKS + 1),
  localparam int unsigned TW             = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          key_pressed_stb_i,
  output logic          event_valid_o,
  output logic [CW-1:0] event_clicks_o,
  input  logic          event_ready_i,
  output logic          event_dropped_o,
  output logic [7:0]    press_total_o
);

  localparam logic [TW-1:0] TimerLoad = TW'(W - 1);
  localparam logic [CW-1:0] MaxCount  = CW'(MAX_CLICKS);

  typedef enum logic [0:0] {StIdle, StCounting} state_e;

  state_e        state_q;
  logic [CW-1:0] clicks_q;
  logic [TW-1:0] timer_q;

  logic          emit;
  logic [CW-1:0] emit_clicks;
  logic [CW-1:0] clicks_inc;
  logic          can_load;

  assign clicks_inc = clicks_q + CW'(1);
  // The output register accepts new data when empty or being drained this very edge.
  assign can_load   = !event_valid_o || event_ready_i;

  always_comb begin
    emit        = 1'b0;
    emit_clicks = clicks_q;
    unique case (state_q)
      StIdle: begin
        if (key_pressed_stb_i && (MAX_CLICKS == 1)) begin
          emit        = 1'b1;
          emit_clicks = CW'(1);
        end
      end
      StCounting: begin
        if (key_pressed_stb_i) begin
          if (clicks_inc == MaxCount) begin
            emit        = 1'b1;
            emit_clicks = clicks_inc;
          end
        end else if (timer_q == '0) begin
          emit        = 1'b1;
          emit_clicks = clicks_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      clicks_q        <= '0;
      timer_q         <= '0;
      event_valid_o   <= 1'b0;
      event_clicks_o  <= '0;
      event_dropped_o <= 1'b0;
      press_total_o   <= '0;
    end else begin
      if (key_pressed_stb_i) begin
        press_total_o <= press_total_o + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (key_pressed_stb_i && (MAX_CLICKS != 1)) begin
            state_q  <= StCounting;
            clicks_q <= CW'(1);
            timer_q  <= TimerLoad;
          end
        end
        StCounting: begin
          if (key_pressed_stb_i) begin
            // A strobe always extends the group, even when the window just expired.
            if (clicks_inc == MaxCount) begin
              state_q  <= StIdle;
              clicks_q <= '0;
              timer_q  <= '0;
            end else begin
              clicks_q <= clicks_inc;
              timer_q  <= TimerLoad;
            end
          end else if (timer_q == '0) begin
            state_q  <= StIdle;
            clicks_q <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      event_dropped_o <= emit && !can_load;
      if (emit && can_load) begin
        event_valid_o  <= 1'b1;
        event_clicks_o <= emit_clicks;
      end else if (event_valid_o && event_ready_i) begin
        event_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with W=8, MAX_CLICKS=3; edges counted from reset release.
module tb_key_click_decoder;

  logic       clk;
  logic       rst;
  logic       stb;
  logic       ready;
  logic       valid;
  logic [1:0] clicks;
  logic       dropped;
  logic [7:0] total;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int e         = 0;
  int nev       = 0;

  key_click_decoder #(
    .CLK_FREQ_MHZ    (1),
    .CLICK_WINDOW_US (8),
    .MAX_CLICKS      (3)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .key_pressed_stb_i (stb),
    .event_valid_o     (valid),
    .event_clicks_o    (clicks),
    .event_ready_i     (ready),
    .event_dropped_o   (dropped),
    .press_total_o     (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    stb   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e   = 0;
    nev = 0;
  endtask

  // Advance to edge 'upto'; strobe on edge k when smask[k] is set. Samples 1 time unit later.
  task automatic go(input int upto, input logic [63:0] smask, input logic rdy);
    while (e < upto) begin
      stb   = smask[e + 1];
      ready = rdy;
      @(posedge clk);
      e++;
      #1;
      stb = 1'b0;
      if (valid && ready) nev++;
    end
  endtask

  logic [63:0] m;

  initial begin
    rst   = 1'b1;
    stb   = 1'b0;
    ready = 1'b1;
    #12;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_clicks", 32'(clicks), 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_total", 32'(total), 0);

    // Single press at 10
    do_reset();
    m = '0; m[10] = 1'b1;
    go(17, m, 1'b1);
    chk("single_early", 32'(valid), 0);
    go(18, m, 1'b1);
    chk("single_valid", 32'(valid), 1);
    chk("single_clicks", 32'(clicks), 1);
    chk("single_total", 32'(total), 1);
    go(19, m, 1'b1);
    chk("single_drain", 32'(valid), 0);

    // Double press on the window boundary (10, 18)
    do_reset();
    m = '0; m[10] = 1'b1; m[18] = 1'b1;
    go(18, m, 1'b1);
    chk("dbl_no18", 32'(valid), 0);
    go(25, m, 1'b1);
    chk("dbl_no25", 32'(valid), 0);
    go(26, m, 1'b1);
    chk("dbl_valid", 32'(valid), 1);
    chk("dbl_clicks", 32'(clicks), 2);
    chk("dbl_total", 32'(total), 2);

    // Just past the window (10, 19): two singles
    do_reset();
    m = '0; m[10] = 1'b1; m[19] = 1'b1;
    go(18, m, 1'b1);
    chk("split_v1", 32'(valid), 1);
    chk("split_c1", 32'(clicks), 1);
    go(26, m, 1'b1);
    chk("split_gap", 32'(valid), 0);
    go(27, m, 1'b1);
    chk("split_v2", 32'(valid), 1);
    chk("split_c2", 32'(clicks), 1);

    // MAX_CLICKS early close (10, 12, 14), new group at 15
    do_reset();
    m = '0; m[10] = 1'b1; m[12] = 1'b1; m[14] = 1'b1; m[15] = 1'b1;
    go(13, m, 1'b1);
    chk("max_early", 32'(valid), 0);
    go(14, m, 1'b1);
    chk("max_valid", 32'(valid), 1);
    chk("max_clicks", 32'(clicks), 3);
    go(22, m, 1'b1);
    chk("max_no22", 32'(valid), 0);
    go(23, m, 1'b1);
    chk("max_new_valid", 32'(valid), 1);
    chk("max_new_clicks", 32'(clicks), 1);
    chk("max_nev", 32'(nev), 2);

    // Backpressure and drop
    do_reset();
    m = '0; m[10] = 1'b1; m[20] = 1'b1; m[22] = 1'b1;
    go(18, m, 1'b0);
    chk("bp_valid", 32'(valid), 1);
    chk("bp_clicks", 32'(clicks), 1);
    go(29, m, 1'b0);
    chk("bp_nodrop29", 32'(dropped), 0);
    go(30, m, 1'b0);
    chk("bp_drop", 32'(dropped), 1);
    chk("bp_hold_clicks", 32'(clicks), 1);
    chk("bp_hold_valid", 32'(valid), 1);
    go(31, m, 1'b0);
    chk("bp_drop_pulse", 32'(dropped), 0);
    go(34, m, 1'b0);
    chk("bp_still_valid", 32'(valid), 1);
    go(35, m, 1'b1);
    chk("bp_drained", 32'(valid), 0);
    chk("bp_total", 32'(total), 3);

    // Drain and load on the same edge
    do_reset();
    m = '0; m[2] = 1'b1; m[12] = 1'b1; m[14] = 1'b1;
    go(21, m, 1'b0);
    chk("dl_pending", 32'(valid), 1);
    chk("dl_old", 32'(clicks), 1);
    go(22, m, 1'b1);
    chk("dl_valid", 32'(valid), 1);
    chk("dl_new", 32'(clicks), 2);
    chk("dl_nodrop", 32'(dropped), 0);
    go(23, m, 1'b1);
    chk("dl_empty", 32'(valid), 0);

    // Reset mid-group
    do_reset();
    m = '0; m[10] = 1'b1; m[12] = 1'b1;
    go(12, m, 1'b1);
    chk("mid_total_pre", 32'(total), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(valid), 0);
    chk("mid_clicks", 32'(clicks), 0);
    chk("mid_dropped", 32'(dropped), 0);
    chk("mid_total", 32'(total), 0);
    @(negedge clk);
    rst = 1'b0;
    m   = '0;
    go(40, m, 1'b1);
    chk("mid_nev", 32'(nev), 0);
    chk("mid_valid40", 32'(valid), 0);
    chk("mid_total40", 32'(total), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
